// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter_if : fetch, load/store and memory-macro signal bundle
// Rev 1.0
// ============================================================================
interface mem_port_arbiter_if;
    // Instruction fetch port
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    // Data load/store port
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_ready;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    // Single-port memory macro
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  if_req, if_addr,
        output if_ready, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        output d_ready, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata
    );

    // Datapath / memory side
    modport master (
        output if_req, if_addr,
        input  if_ready, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata, d_be,
        input  d_ready, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : shares one single-port memory between fetch and LSU with
// fixed-latency sequencing and starvation-protected data-first priority.
// Optional stall counters: define ARB_PERF_CNT_EN.
// Rev 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    mem_port_arbiter_if.slave   bus,
`ifdef ARB_PERF_CNT_EN
    output logic [31:0]         if_stall_cnt,
    output logic [31:0]         d_stall_cnt,
`endif
    output logic                busy
);

    localparam logic [2:0] c_lat_load   = 3'(MEM_LATENCY);
    localparam logic [3:0] c_starve_max = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t      state_q,     state_d;
    logic [2:0]  lat_cnt_q,   lat_cnt_d;
    logic [3:0]  starve_q,    starve_d;
    logic        owner_d_q,   owner_d_d;
    logic        mem_en_q,    mem_en_d;
    logic        mem_we_q,    mem_we_d;
    logic [31:0] mem_addr_q,  mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q,    mem_be_d;
    logic        if_rvalid_q, if_rvalid_d;
    logic [31:0] if_rdata_q,  if_rdata_d;
    logic        d_rvalid_q,  d_rvalid_d;
    logic [31:0] d_rdata_q,   d_rdata_d;
    logic        busy_q,      busy_d;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] if_stall_q,  if_stall_d;
    logic [31:0] d_stall_q,   d_stall_d;
`endif

    logic w_idle;
    logic w_grant_fetch;
    logic w_if_ready;
    logic w_d_ready;

    // Data wins a tie unless fetch has been passed over STARVE_LIMIT times
    assign w_idle        = (state_q == ST_IDLE);
    assign w_grant_fetch = bus.if_req && (!bus.d_req || (starve_q == c_starve_max));
    assign w_if_ready    = reset_n && w_idle && w_grant_fetch;
    assign w_d_ready     = reset_n && w_idle && bus.d_req && !w_grant_fetch;

    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        starve_d    = starve_q;
        owner_d_d   = owner_d_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rvalid_d  = 1'b0;
        d_rdata_d   = d_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (w_if_ready) begin
                    starve_d = 4'd0;
                end else if (w_d_ready && bus.if_req) begin
                    starve_d = (starve_q == c_starve_max) ? starve_q : starve_q + 4'd1;
                end else if (!bus.if_req) begin
                    starve_d = 4'd0;
                end

                if (w_if_ready) begin
                    state_d     = ST_ISSUE;
                    owner_d_d   = 1'b0;
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.if_addr;
                    mem_wdata_d = 32'd0;
                    mem_be_d    = 4'hF;
                end else if (w_d_ready) begin
                    state_d     = ST_ISSUE;
                    owner_d_d   = 1'b1;
                    mem_en_d    = 1'b1;
                    mem_we_d    = bus.d_we;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_we ? bus.d_wdata : 32'd0;
                    mem_be_d    = bus.d_we ? bus.d_be : 4'hF;
                end
            end
            ST_ISSUE: begin
                lat_cnt_d = c_lat_load;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                lat_cnt_d = lat_cnt_q - 3'd1;
                // Final wait cycle: read data is valid on mem_rdata now
                if (lat_cnt_q == 3'd1) begin
                    state_d = ST_RESP;
                    if (owner_d_q) begin
                        d_rvalid_d = 1'b1;
                        d_rdata_d  = mem_we_q ? 32'd0 : bus.mem_rdata;
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = bus.mem_rdata;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

`ifdef ARB_PERF_CNT_EN
    always_comb begin
        if_stall_d = if_stall_q;
        d_stall_d  = d_stall_q;
        if (bus.if_req && !w_if_ready && (if_stall_q != 32'hFFFF_FFFF)) begin
            if_stall_d = if_stall_q + 32'd1;
        end
        if (bus.d_req && !w_d_ready && (d_stall_q != 32'hFFFF_FFFF)) begin
            d_stall_d = d_stall_q + 32'd1;
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            lat_cnt_q   <= 3'd0;
            starve_q    <= 4'd0;
            owner_d_q   <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_be_q    <= 4'd0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= 32'd0;
            d_rvalid_q  <= 1'b0;
            d_rdata_q   <= 32'd0;
            busy_q      <= 1'b0;
`ifdef ARB_PERF_CNT_EN
            if_stall_q  <= 32'd0;
            d_stall_q   <= 32'd0;
`endif
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            starve_q    <= starve_d;
            owner_d_q   <= owner_d_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            if_rvalid_q <= if_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rvalid_q  <= d_rvalid_d;
            d_rdata_q   <= d_rdata_d;
            busy_q      <= busy_d;
`ifdef ARB_PERF_CNT_EN
            if_stall_q  <= if_stall_d;
            d_stall_q   <= d_stall_d;
`endif
        end
    end

    assign bus.if_ready  = w_if_ready;
    assign bus.d_ready   = w_d_ready;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;
    assign busy          = busy_q;
`ifdef ARB_PERF_CNT_EN
    assign if_stall_cnt  = if_stall_q;
    assign d_stall_cnt   = d_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter : transaction-level model plus directed vectors
// Rev 1.0
// ============================================================================
module tb_mem_port_arbiter;
    localparam int LAT_A   = 1;
    localparam int LIMIT_A = 4;
    localparam int LAT_B   = 3;

    logic clock     = 1'b0;
    logic reset_n   = 1'b0;
    logic reset_n_b = 1'b0;
    logic a_busy, b_busy;

    mem_port_arbiter_if a_if ();
    mem_port_arbiter_if b_if ();

`ifdef ARB_PERF_CNT_EN
    logic [31:0] a_ifs, a_ds, b_ifs, b_ds;
`endif

    mem_port_arbiter #(.MEM_LATENCY(LAT_A), .STARVE_LIMIT(LIMIT_A)) u_dut_a (
        .clock        (clock),
        .reset_n      (reset_n),
        .bus          (a_if.slave),
`ifdef ARB_PERF_CNT_EN
        .if_stall_cnt (a_ifs),
        .d_stall_cnt  (a_ds),
`endif
        .busy         (a_busy)
    );

    mem_port_arbiter #(.MEM_LATENCY(LAT_B), .STARVE_LIMIT(LIMIT_A)) u_dut_b (
        .clock        (clock),
        .reset_n      (reset_n_b),
        .bus          (b_if.slave),
`ifdef ARB_PERF_CNT_EN
        .if_stall_cnt (b_ifs),
        .d_stall_cnt  (b_ds),
`endif
        .busy         (b_busy)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, 32'(act), 32'(exp));
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    logic [31:0] ref_mem [256];
    logic [31:0] dev_mem [256];

    // Transaction-level reference: one transaction at a time, events at fixed offsets
    int          cyc     = 0;
    bit          armed   = 1'b0;
    int          free_at = 0;
    int          tx_acc  = -100;
    bit          tx_f    = 1'b0;
    bit          tx_we   = 1'b0;
    logic [31:0] tx_addr = '0, tx_wdata = '0, tx_data = '0;
    logic [3:0]  tx_be   = '0;
    int          starve  = 0;
    logic [31:0] m_if_rdata = '0, m_d_rdata = '0;
    logic [31:0] m_ifs = '0, m_ds = '0;
    int          a_due  = -1;
    logic [31:0] a_word = '0;

    always @(negedge clock) begin
        bit idle, gf, e_ifr, e_dr, e_en, e_rv;
        // memory device for DUT A: data appears exactly LAT_A cycles after mem_en
        a_if.mem_rdata = (cyc == a_due) ? a_word : (32'hBAD0_0000 ^ 32'(cyc));
        if (a_if.mem_en === 1'b1) begin
            if (a_if.mem_we === 1'b1)
                dev_mem[a_if.mem_addr[9:2]] = merge(dev_mem[a_if.mem_addr[9:2]], a_if.mem_wdata, a_if.mem_be);
            else begin
                a_due  = cyc + LAT_A;
                a_word = dev_mem[a_if.mem_addr[9:2]];
            end
        end

        idle  = (cyc >= free_at);
        gf    = a_if.if_req && (!a_if.d_req || (starve == LIMIT_A));
        e_ifr = reset_n && idle && gf;
        e_dr  = reset_n && idle && a_if.d_req && !gf;
        e_en  = (cyc == tx_acc + 1);
        e_rv  = (cyc == tx_acc + LAT_A + 2);
        if (e_rv) begin
            if (tx_f) m_if_rdata = tx_data;
            else      m_d_rdata  = tx_data;
        end

        if (armed) begin
            chk1("if_ready", a_if.if_ready, e_ifr);
            chk1("d_ready", a_if.d_ready, e_dr);
            chk1("mem_en", a_if.mem_en, e_en);
            if (e_en) begin
                chk1("mem_we", a_if.mem_we, tx_we);
                chk("mem_addr", a_if.mem_addr, tx_addr);
                chk("mem_be", 32'(a_if.mem_be), 32'(tx_be));
                if (tx_we) chk("mem_wdata", a_if.mem_wdata, tx_wdata);
            end
            chk1("if_rvalid", a_if.if_rvalid, e_rv && tx_f);
            chk1("d_rvalid", a_if.d_rvalid, e_rv && !tx_f);
            chk("if_rdata", a_if.if_rdata, m_if_rdata);
            chk("d_rdata", a_if.d_rdata, m_d_rdata);
            chk1("busy", a_busy, !idle);
`ifdef ARB_PERF_CNT_EN
            chk("if_stall_cnt", a_ifs, m_ifs);
            chk("d_stall_cnt", a_ds, m_ds);
`endif
        end

        if (!reset_n) begin
            tx_acc     = -100;
            free_at    = cyc + 1;
            starve     = 0;
            m_if_rdata = '0;
            m_d_rdata  = '0;
            m_ifs      = '0;
            m_ds       = '0;
            armed      = 1'b1;
        end else begin
            if (a_if.if_req && !e_ifr && m_ifs != 32'hFFFF_FFFF) m_ifs = m_ifs + 1;
            if (a_if.d_req  && !e_dr  && m_ds  != 32'hFFFF_FFFF) m_ds  = m_ds + 1;
            if (idle) begin
                if (e_ifr || e_dr) begin
                    tx_acc  = cyc;
                    free_at = cyc + LAT_A + 3;
                    tx_f    = e_ifr;
                    tx_we   = e_dr && a_if.d_we;
                    tx_addr = e_ifr ? a_if.if_addr : a_if.d_addr;
                    tx_be   = tx_we ? a_if.d_be : 4'hF;
                    tx_wdata = a_if.d_wdata;
                    if (tx_we) begin
                        ref_mem[tx_addr[9:2]] = merge(ref_mem[tx_addr[9:2]], tx_wdata, tx_be);
                        tx_data = '0;
                    end else begin
                        tx_data = ref_mem[tx_addr[9:2]];
                    end
                end
                if (e_ifr)                   starve = 0;
                else if (e_dr && a_if.if_req) starve = (starve == LIMIT_A) ? starve : starve + 1;
                else if (!a_if.if_req)        starve = 0;
            end
        end
        cyc++;
    end

    // Memory device for DUT B
    int          bcyc  = 0;
    int          b_due = -1;
    logic [31:0] b_word = '0;
    always @(negedge clock) begin
        b_if.mem_rdata = (bcyc == b_due) ? b_word : 32'hBAD0_BAD0;
        if (b_if.mem_en === 1'b1) begin
            b_due  = bcyc + LAT_B;
            b_word = 32'hA5A5_0000 | {16'h0, b_if.mem_addr[15:0]};
        end
        bcyc++;
    end

    task automatic req_txn(input bit fetch, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be);
        bit got;
        got = 1'b0;
        @(posedge clock); #1;
        if (fetch) begin
            a_if.if_req = 1'b1; a_if.if_addr = addr;
        end else begin
            a_if.d_req = 1'b1; a_if.d_we = we; a_if.d_addr = addr;
            a_if.d_wdata = wdata; a_if.d_be = be;
        end
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clock);
            if ((fetch && a_if.if_ready) || (!fetch && a_if.d_ready)) got = 1'b1;
        end
        chk1("accept_timeout", got, 1'b1);
        @(posedge clock); #1;
        a_if.if_req = 1'b0;
        a_if.d_req  = 1'b0;
        a_if.d_we   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0]  seq;
        int          ng;
        int          k, t1, t2, en1, rv1;
        logic [31:0] rd1;

        a_if.if_req = 0; a_if.if_addr = 0; a_if.d_req = 0; a_if.d_we = 0;
        a_if.d_addr = 0; a_if.d_wdata = 0; a_if.d_be = 0;
        b_if.if_req = 0; b_if.if_addr = 0; b_if.d_req = 0; b_if.d_we = 0;
        b_if.d_addr = 0; b_if.d_wdata = 0; b_if.d_be = 0;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 32'h1000_0000 + 32'(i * 4);
            dev_mem[i] = ref_mem[i];
        end
        ref_mem[4]     = 32'h0000_0013; dev_mem[4]     = 32'h0000_0013;
        ref_mem[8'h40] = 32'h1122_3344; dev_mem[8'h40] = 32'h1122_3344;

        // Reset held for two rising edges
        @(posedge clock);
        @(negedge clock);
        chk1("rst_busy", a_busy, 1'b0);
        chk1("rst_mem_en", a_if.mem_en, 1'b0);
        chk("rst_if_rdata", a_if.if_rdata, 32'h0);
        chk("rst_d_rdata", a_if.d_rdata, 32'h0);
        @(posedge clock); #1;
        reset_n = 1'b1;

        // Single fetch at 0x10
        req_txn(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        @(negedge clock);
        chk1("fetch_mem_en_T1", a_if.mem_en, 1'b1);
        chk("fetch_mem_addr_T1", a_if.mem_addr, 32'h10);
        repeat (2) @(negedge clock);
        chk1("fetch_rvalid_T3", a_if.if_rvalid, 1'b1);
        chk("fetch_rdata_T3", a_if.if_rdata, 32'h13);

        // Partial store then load at 0x100
        req_txn(1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'b0011);
        @(negedge clock);
        chk1("store_mem_we", a_if.mem_we, 1'b1);
        chk("store_mem_be", 32'(a_if.mem_be), 32'h3);
        chk("store_mem_wdata", a_if.mem_wdata, 32'hDEAD_BEEF);
        repeat (2) @(negedge clock);
        chk1("store_ack", a_if.d_rvalid, 1'b1);
        chk("store_rdata", a_if.d_rdata, 32'h0);

        req_txn(1'b0, 1'b0, 32'h100, 32'h0, 4'h0);
        @(negedge clock);
        chk1("load_mem_we", a_if.mem_we, 1'b0);
        chk("load_mem_be", 32'(a_if.mem_be), 32'hF);
        repeat (2) @(negedge clock);
        chk1("load_rvalid", a_if.d_rvalid, 1'b1);
        chk("load_rdata", a_if.d_rdata, 32'h1122_BEEF);
        chk("if_rdata_held", a_if.if_rdata, 32'h13);

        // Both ports requesting continuously
        @(posedge clock); #1;
        a_if.if_req = 1'b1; a_if.if_addr = 32'h30;
        a_if.d_req  = 1'b1; a_if.d_we = 1'b0; a_if.d_addr = 32'h104;
        seq = '0;
        ng  = 0;
        for (int c = 0; c < 300 && ng < 10; c++) begin
            @(negedge clock);
            if (a_if.if_ready || a_if.d_ready) begin
                seq = {seq[8:0], a_if.if_ready};
                ng++;
            end
        end
        @(posedge clock); #1;
        a_if.if_req = 1'b0; a_if.d_req = 1'b0;
        chk("grant_seq", 32'(seq), 32'(10'b0000100001));
        repeat (6) @(posedge clock);

        // Reset during WAIT aborts the fetch
        req_txn(1'b1, 1'b0, 32'h30, 32'h0, 4'h0);
        @(posedge clock); #1;
        reset_n = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(negedge clock);
        chk1("abort_no_rvalid", a_if.if_rvalid, 1'b0);
        chk1("abort_idle", a_busy, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            chk1("abort_no_if_rvalid", a_if.if_rvalid, 1'b0);
            chk1("abort_no_d_rvalid", a_if.d_rvalid, 1'b0);
        end
        req_txn(1'b0, 1'b0, 32'h100, 32'h0, 4'h0);
        repeat (3) @(negedge clock);
        chk1("post_abort_rvalid", a_if.d_rvalid, 1'b1);
        chk("post_abort_rdata", a_if.d_rdata, 32'h1122_BEEF);

        // MEM_LATENCY = 3: back-to-back fetches on DUT B
        @(posedge clock); #1;
        reset_n_b   = 1'b1;
        b_if.if_req = 1'b1; b_if.if_addr = 32'h20;
        k = 0; t1 = -1; t2 = -1; en1 = -1; rv1 = -1; rd1 = '0;
        while (k < 80 && t2 < 0) begin
            @(negedge clock);
            if (b_if.if_ready) begin
                if (t1 < 0) t1 = k;
                else        t2 = k;
            end
            if (b_if.mem_en && en1 < 0) en1 = k;
            if (b_if.if_rvalid && rv1 < 0) begin
                rv1 = k;
                rd1 = b_if.if_rdata;
            end
            k++;
        end
        @(posedge clock); #1;
        b_if.if_req = 1'b0;
        chk("lat3_issue_interval", 32'(t2 - t1), 32'd6);
        chk("lat3_mem_en_offset", 32'(en1 - t1), 32'd1);
        chk("lat3_rvalid_offset", 32'(rv1 - t1), 32'd5);
        chk("lat3_rdata", rd1, 32'hA5A5_0020);

        repeat (8) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between instruction fetch and data load/store of the RISC-V datapath.
- Uses valid/ready request handshakes, a fixed-latency memory sequencer and starvation-protected priority arbitration.
- Sits between the datapath's fetch/LSU interfaces and the memory macro.
- The datapath stalls while its port's ready or rvalid is pending.

Parameters:
- MEM_LATENCY, 1, memory read latency in cycles from mem_en to valid mem_rdata (legal 1..4).
- STARVE_LIMIT, 4, consecutive data grants allowed while if_req is pending before fetch is forced to win (legal 1..15).

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  synchronous active-low reset
- if_req  in  1  fetch request
- if_addr  in  32  fetch byte address
- if_ready  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch data valid, 1-cycle pulse
- if_rdata  out  32  fetch data
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_be  in  4  store byte enables
- d_ready  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid / store ack, 1-cycle pulse
- d_rdata  out  32  load data (0 on store ack)
- mem_en  out  1  memory access strobe, 1 cycle
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_be  out  4  memory byte enables (4'hF for reads)
- mem_rdata  in  32  memory read data
- busy  out  1  transaction in flight (state != IDLE)

Behaviour:
- The clock port is named clock; reset is synchronous and active-low on reset_n.
- Reset values:
  - state = IDLE.
  - All outputs 0, including if_rdata and d_rdata.
  - Latency counter = 0; starvation counter = 0.
- States:
  - IDLE: ready may assert; acceptance moves to ISSUE.
  - ISSUE (1 cycle): mem_en = 1 with registered addr/we/wdata/be; counter loads MEM_LATENCY; go to WAIT.
  - WAIT: counter decrements each cycle. When the counter reaches 0, capture mem_rdata into the owner's rdata register and go to RESP.
  - RESP (1 cycle): owner's rvalid = 1; go to IDLE.
- Acceptance happens in cycle T when req && ready, and only in IDLE.
  - mem_en asserts in T+1.
  - rvalid asserts in T+MEM_LATENCY+2.
- Minimum issue interval: MEM_LATENCY+3 cycles.
- if_ready and d_ready are combinational from state, grant and req. At most one is high in any cycle.
- Grant in IDLE:
  - Only one req: that port wins.
  - Both req: data wins unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
- Starvation counter:
  - Increments on a data grant while if_req = 1.
  - Clears on a fetch grant, or in any IDLE cycle with if_req = 0.
  - Saturates at STARVE_LIMIT.
- Store transactions follow the same state path. mem_rdata is ignored; d_rvalid pulses with d_rdata = 0.
- Requester signals are sampled only in the acceptance cycle. Changes after acceptance do not affect the in-flight transaction.
- Only the owner's rdata register updates; the other port's rdata holds its value.
- rdata holds until that port's next completion.
- Reset asserted in any state:
  - Aborts the transaction next edge; no rvalid is produced.
  - mem_en is 0 in the cycle after reset is sampled.
- mem_en never asserts outside ISSUE.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- When defined, adds the following outputs, cleared by reset and saturating at 2^32-1:
  - if_stall_cnt out 32: counts cycles with if_req = 1 && if_ready = 0.
  - d_stall_cnt out 32: counts cycles with d_req = 1 && d_ready = 0.
- When not defined, these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset and single fetch: reset_n = 0 for 2 cycles, then fetch-only read at 0x0000_0010 with MEM_LATENCY = 1 and mem_rdata = 0x0000_0013.
  - All outputs are 0 during reset.
  - if_ready at T, mem_en/mem_addr = 0x10 at T+1, if_rvalid = 1 with if_rdata = 0x13 at T+3.
- Store then load to 0x100:
  - Store: wdata 0xDEADBEEF, be 4'b0011.
  - Expect mem_we = 1, mem_be = 4'b0011, and a d_rvalid pulse with d_rdata = 0.
  - Load: mem_be = 4'hF, mem_we = 0, and d_rdata equals the memory model's value.
- Both requests held continuously with STARVE_LIMIT = 4: grants are D,D,D,D,F,D,D,D,D,F; if_rvalid never pulses for a data transaction.
- MEM_LATENCY = 3, back-to-back fetches: the second if_ready occurs exactly 6 cycles after the first; if_rvalid at T+5.
- reset_n = 0 during WAIT: no if_rvalid or d_rvalid afterwards, state returns to IDLE, and the next request completes normally.
- With ARB_PERF_CNT_EN, both requests held 20 cycles from IDLE with MEM_LATENCY = 1: if_stall_cnt + d_stall_cnt equals the number of non-accept requesting cycles computed by the bench model.
